// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: state encoding, bus widths
// and the default response latency.
package mem_pkg;

    localparam int WORD_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int DEF_LATENCY = 2;
    localparam int CNT_W       = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered read port that holds its
// value until the next read; only the read register is cleared by reset.
module mem_array #(
    parameter int DATA_W    = 16,
    parameter int ADDR_BITS = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge Clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read or write strobe at a time, waits
// LATENCY cycles, then performs the access and pulses memReady (and busErr).
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY   = DEF_LATENCY,
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata,
    output logic                 memReady,
    output logic                 busErr
);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 err;
    logic [ADDR_BITS-1:0] lat_addr;
    logic [DATA_W-1:0]    lat_wdata;
    logic                 lat_we;
    logic                 single_req;
    logic                 dual_req;
    logic                 arr_en;

    function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
        return (a >> ADDR_BITS) != '0;
    endfunction

    assign single_req = MemRead ^ MemWrite;
    assign dual_req   = MemRead & MemWrite;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (single_req) begin
                        state <= ST_BUSY;
                        cnt   <= CNT_W'(LATENCY);
                        err   <= addr_oob(addr);
                    end else if (dual_req) begin
                        state <= ST_RESP;
                        err   <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request capture: only updated when IDLE accepts a single strobe
    always_ff @(posedge Clk) begin
        if (state == ST_IDLE && single_req) begin
            lat_addr  <= addr[ADDR_BITS-1:0];
            lat_wdata <= wdata;
            lat_we    <= MemWrite;
        end
    end

    // The array is touched only on the BUSY->RESP edge of an error-free access
    assign arr_en   = (state == ST_BUSY) && (cnt == '0) && !err;
    assign memReady = (state == ST_RESP);
    assign busErr   = (state == ST_RESP) && err;

    mem_array #(
        .DATA_W    (DATA_W),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (arr_en),
        .we    (lat_we),
        .addr  (lat_addr),
        .wdata (lat_wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, reset/abort and strobe-ignore
// sequences, randomized accesses against a word-array model, LATENCY=0 build.
module tb_mem_responder;

    logic        Clk;
    logic        Reset;
    logic        MemRead, MemWrite;
    logic [15:0] addr, wdata, rdata;
    logic        memReady, busErr;

    logic        r0, w0;
    logic [15:0] a0, d0, rdata0;
    logic        ready0, err0;

    int checks = 0;
    int errors = 0;

    localparam int LAT = 2;

    mem_responder #(.LATENCY(LAT), .ADDR_BITS(8), .DATA_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .memReady(memReady), .busErr(busErr)
    );

    mem_responder #(.LATENCY(0), .ADDR_BITS(8), .DATA_W(16)) dut0 (
        .Clk(Clk), .Reset(Reset), .MemRead(r0), .MemWrite(w0),
        .addr(a0), .wdata(d0), .rdata(rdata0),
        .memReady(ready0), .busErr(err0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        int          dly;
        logic        err;
        logic [15:0] rdat;
    } vec_t;

    vec_t        tbl [7];
    logic [15:0] mm [256];
    logic [15:0] mrd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One access on the main DUT; strobes drop after the sampling edge
    task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, output int dly, output logic err,
                          output logic [15:0] rq);
        @(negedge Clk);
        MemRead = rd; MemWrite = wr; addr = a; wdata = d;
        @(negedge Clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        dly = -1; err = 1'b0; rq = rdata;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge Clk);
            if (memReady) begin
                dly = k; err = busErr; rq = rdata;
                break;
            end
            chk("busErr_without_ready", {31'b0, busErr}, 32'd0);
        end
        if (dly > 0) begin
            @(negedge Clk);
            chk("ready_single_cycle", {31'b0, memReady}, 32'd0);
        end
    endtask

    task automatic access0(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, output int dly, output logic [15:0] rq);
        @(negedge Clk);
        r0 = rd; w0 = wr; a0 = a; d0 = d;
        @(negedge Clk);
        r0 = 1'b0; w0 = 1'b0;
        dly = -1; rq = rdata0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge Clk);
            if (ready0) begin
                dly = k; rq = rdata0;
                break;
            end
        end
        @(negedge Clk);
    endtask

    // Reference rules: both strobes -> immediate error response; otherwise
    // response LAT+2 negedges after issue, error when address beyond 8 bits
    task automatic model_op(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [15:0] d, output int dly, output logic err);
        if (rd && wr) begin
            dly = 1; err = 1'b1;
        end else begin
            dly = LAT + 2;
            err = (a > 16'd255);
            if (!err && wr) mm[a[7:0]] = d;
            if (!err && rd) mrd = mm[a[7:0]];
        end
    endtask

    initial begin
        int          dly, edly;
        logic        err, eerr;
        logic [15:0] rq, d;
        logic        rd, wr;
        logic [15:0] a;
        int          pick;

        tbl[0] = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 4, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 4, 1'b0, 16'hBEEF};
        tbl[2] = '{1'b0, 1'b1, 16'h0003, 16'h5555, 4, 1'b0, 16'hBEEF};
        tbl[3] = '{1'b1, 1'b1, 16'h0003, 16'hAAAA, 1, 1'b1, 16'hBEEF};
        tbl[4] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 4, 1'b0, 16'h5555};
        tbl[5] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 4, 1'b1, 16'h5555};
        tbl[6] = '{1'b0, 1'b1, 16'h0007, 16'h0777, 4, 1'b0, 16'h5555};

        MemRead = 0; MemWrite = 0; addr = 0; wdata = 0;
        r0 = 0; w0 = 0; a0 = 0; d0 = 0;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("reset_rdata", {16'b0, rdata}, 32'h0);
        chk("reset_ready", {31'b0, memReady}, 32'd0);
        chk("reset_busErr", {31'b0, busErr}, 32'd0);
        Reset = 1'b0;

        foreach (tbl[i]) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, dly, err, rq);
            chk($sformatf("tbl%0d_latency", i), dly, tbl[i].dly);
            chk($sformatf("tbl%0d_busErr", i), {31'b0, err}, {31'b0, tbl[i].err});
            chk($sformatf("tbl%0d_rdata", i), {16'b0, rq}, {16'b0, tbl[i].rdat});
            @(negedge Clk);
            chk($sformatf("tbl%0d_rdata_held", i), {16'b0, rdata}, {16'b0, tbl[i].rdat});
        end

        // Reset while a write to 7 is in BUSY: write must be lost
        @(negedge Clk);
        MemWrite = 1'b1; addr = 16'h0007; wdata = 16'h1234;
        @(negedge Clk);
        MemWrite = 1'b0;
        Reset = 1'b1;
        #1;
        chk("abort_ready", {31'b0, memReady}, 32'd0);
        chk("abort_rdata", {16'b0, rdata}, 32'h0);
        #1 Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            chk("abort_no_ready", {31'b0, memReady}, 32'd0);
        end
        access(1'b1, 1'b0, 16'h0007, 16'h0, dly, err, rq);
        chk("abort_read_latency", dly, 4);
        chk("abort_read_value", {16'b0, rq}, 32'h0777);

        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            model_op(1'b0, 1'b1, 16'(i), d, edly, eerr);
            access(1'b0, 1'b1, 16'(i), d, dly, err, rq);
            chk("init_latency", dly, edly);
        end
        mrd = 16'h0777;

        // Strobes during BUSY must not disturb the latched write
        @(negedge Clk);
        MemWrite = 1'b1; addr = 16'h0004; wdata = 16'h4444;
        @(negedge Clk);
        MemWrite = 1'b0; MemRead = 1'b1; addr = 16'h0006; wdata = 16'hDEAD;
        @(negedge Clk);
        MemRead = 1'b0; MemWrite = 1'b1;
        @(negedge Clk);
        MemWrite = 1'b0;
        @(negedge Clk);
        chk("busy_ignore_ready", {31'b0, memReady}, 32'd1);
        chk("busy_ignore_err", {31'b0, busErr}, 32'd0);
        mm[4] = 16'h4444;
        @(negedge Clk);
        access(1'b1, 1'b0, 16'h0004, 16'h0, dly, err, rq);
        chk("busy_ignore_rd4", {16'b0, rq}, {16'b0, mm[4]});
        access(1'b1, 1'b0, 16'h0006, 16'h0, dly, err, rq);
        chk("busy_ignore_rd6", {16'b0, rq}, {16'b0, mm[6]});
        mrd = mm[6];

        for (int n = 0; n < 40; n++) begin
            pick = int'($urandom_range(0, 9));
            a = (pick < 8) ? 16'(pick) : ((pick == 8) ? 16'h0100 : 16'hFF07);
            pick = int'($urandom_range(0, 5));
            rd = (pick <= 2) || (pick == 5);
            wr = (pick >= 3);
            d  = 16'($urandom);
            model_op(rd, wr, a, d, edly, eerr);
            access(rd, wr, a, d, dly, err, rq);
            chk("rand_latency", dly, edly);
            chk("rand_busErr", {31'b0, err}, {31'b0, eerr});
            chk("rand_rdata", {16'b0, rq}, {16'b0, mrd});
        end

        // LATENCY=0 build: strobe held, pulses every 3rd cycle
        access0(1'b0, 1'b1, 16'h000A, 16'h0A0A, dly, rq);
        chk("lat0_single_latency", dly, 2);
        @(negedge Clk);
        w0 = 1'b1; a0 = 16'h0002; d0 = 16'h00A0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            chk($sformatf("lat0_ready_k%0d", k), {31'b0, ready0}, {31'b0, k % 3 == 2});
            if (k == 12) begin
                w0 = 1'b0;
            end else if (k % 3 == 0) begin
                a0 = 16'h0002; d0 = 16'(16'h00A0 + k);
            end else begin
                a0 = 16'h000A; d0 = 16'hDEAD;
            end
        end
        access0(1'b1, 1'b0, 16'h0002, 16'h0, dly, rq);
        chk("lat0_rd2", {16'b0, rq}, 32'h00A9);
        access0(1'b1, 1'b0, 16'h000A, 16'h0, dly, rq);
        chk("lat0_rdA", {16'b0, rq}, 32'h0A0A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
